grad_round_clip_pipe: RTL and testbench

- Streaming, multi-channel successor to the single-word Q8.8 round-and-cap converter used in the 4D gradient-descent datapath.
- Each accepted input vector carries NUM_CH signed fixed-point gradient words; every word is:
  - rounded to an integer under a selectable mode,
  - optionally clipped to a runtime symmetric limit,
  - saturated to OUT_W bits.
- Sits between the gradient computation stage and the parameter-update stage, with valid/ready backpressure.
- Maintains a saturating count of vectors that needed clipping or saturation.

---
 rtl/grad_round_clip_pipe_if.sv | 40 ++++
 rtl/grad_round_clip_pipe.sv | 187 ++++++++++++++++++
 tb/tb_grad_round_clip_pipe.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/grad_round_clip_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : grad_round_clip_pipe_if
//  Description : Stream bundle for grad_round_clip_pipe. It carries the input
//                vector with its per-vector config and the output vector with
//                its per-channel saturation flags, each with valid/ready.
//                master : the side that produces input vectors and consumes
//                         results (the surrounding datapath)
//                slave  : the rounding/clipping pipeline itself
//                Signals: in_valid/in_ready/in_data/mode/clip_en/clip_lim,
//                         out_valid/out_ready/out_data/out_sat
//  Revision    : 1.0 - initial release
// ============================================================================
interface grad_round_clip_pipe_if #(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 16,
    parameter int OUT_W  = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_CH*IN_W-1:0]  in_data;
    logic [1:0]              mode;
    logic                    clip_en;
    logic [OUT_W-2:0]        clip_lim;
    logic                    out_valid;
    logic                    out_ready;
    logic [NUM_CH*OUT_W-1:0] out_data;
    logic [NUM_CH-1:0]       out_sat;

    modport master (
        output in_valid, in_data, mode, clip_en, clip_lim, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, mode, clip_en, clip_lim, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface
`default_nettype wire

// File: rtl/grad_round_clip_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : grad_round_clip_pipe
//  Description : Two-stage streaming converter from signed fixed-point
//                gradient words to saturated signed integers.
//                S1 rounds every channel (half-up, floor or half away from
//                zero); S2 clamps to a runtime symmetric limit or to the
//                OUT_W range and flags channels whose value changed.
//                Config travels with the vector through the pipe.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                bus (slave)  - input/output streams, see the interface
//                cnt_clr      - synchronous clear of sat_cnt
//                sat_cnt      - saturating count of delivered vectors with
//                               any out_sat bit set
//  Revision    : 1.0 - initial release
// ============================================================================
module grad_round_clip_pipe #(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 16,
    parameter int FRAC   = 8,
    parameter int OUT_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    grad_round_clip_pipe_if.slave bus,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      sat_cnt
);

    // Rounded integers are held at IN_W-FRAC+1 bits: one more than the
    // integer part, so +0.5 on the largest input and negation of the most
    // negative input both stay representable.
    localparam int WW = IN_W - FRAC + 1;
    // The rounding sums themselves need one guard bit above IN_W.
    localparam int XW = IN_W + 1;

    localparam logic signed [XW-1:0] HALF = XW'(1) << (FRAC - 1);
    localparam logic signed [WW-1:0] MAXV = {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WW-1:0] MINV = ~MAXV;

    // ------------------------------------------------------------------
    // Handshake: each stage may advance when it is empty or the stage
    // after it is advancing.
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    // ------------------------------------------------------------------
    // S1 combinational: rounding per channel
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0][WW-1:0] round_all;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_round
        logic signed [IN_W-1:0] x;
        logic signed [XW-1:0]   x_ext;
        logic signed [XW-1:0]   up_sum;
        logic signed [XW-1:0]   neg_sum;
        logic signed [WW-1:0]   r_up;
        logic signed [WW-1:0]   r_tr;
        logic signed [WW-1:0]   mag;
        logic signed [WW-1:0]   r_sel;

        assign x       = bus.in_data[k*IN_W +: IN_W];
        assign x_ext   = {x[IN_W-1], x};
        assign up_sum  = x_ext + HALF;
        // For negative x, -x is positive, so the magnitude sum has a clear
        // top bit and dropping the fraction is a plain logical shift.
        assign neg_sum = (-x_ext) + HALF;

        // Taking bits [XW-1:FRAC] is the arithmetic shift by FRAC, already
        // at width WW.
        assign r_up = up_sum[XW-1:FRAC];
        assign r_tr = x_ext[XW-1:FRAC];
        assign mag  = neg_sum[XW-1:FRAC];

        always_comb begin
            r_sel = r_up;
            case (bus.mode)
                2'd1:    r_sel = r_tr;
                2'd2:    r_sel = x[IN_W-1] ? -mag : r_up;
                default: r_sel = r_up;
            endcase
        end

        assign round_all[k] = r_sel;
    end

    // ------------------------------------------------------------------
    // S1 registers: rounded values plus the clip config of this vector
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0][WW-1:0] s1_r;
    logic                      s1_clip_en;
    logic [OUT_W-2:0]          s1_lim;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_r       <= '0;
            s1_clip_en <= 1'b0;
            s1_lim     <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_r       <= round_all;
                s1_clip_en <= bus.clip_en;
                s1_lim     <= bus.clip_lim;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2 combinational: clamp and flag
    // ------------------------------------------------------------------
    logic signed [WW-1:0]         lim_ext;
    logic [NUM_CH*OUT_W-1:0]      clip_data;
    logic [NUM_CH-1:0]            clip_sat;

    assign lim_ext = {{(WW-OUT_W+1){1'b0}}, s1_lim};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_clip
        logic signed [WW-1:0] r;
        logic signed [WW-1:0] hi;
        logic signed [WW-1:0] lo;
        logic signed [WW-1:0] clamped;
        logic                 over;
        logic                 under;

        assign r       = s1_r[k];
        assign hi      = s1_clip_en ? lim_ext  : MAXV;
        assign lo      = s1_clip_en ? -lim_ext : MINV;
        assign over    = r > hi;
        assign under   = r < lo;
        assign clamped = over ? hi : (under ? lo : r);

        assign clip_data[k*OUT_W +: OUT_W] = clamped[OUT_W-1:0];
        assign clip_sat[k]                 = over | under;
    end

    // ------------------------------------------------------------------
    // S2 registers drive the output stream directly; they only load when
    // the stage advances, which keeps them stable under backpressure.
    // ------------------------------------------------------------------
    logic [NUM_CH*OUT_W-1:0] s2_data;
    logic [NUM_CH-1:0]       s2_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_sat   <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= clip_data;
                s2_sat  <= clip_sat;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_sat   = s2_sat;

    // ------------------------------------------------------------------
    // Saturation-event counter: clear beats increment, sticks at all-ones
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt <= '0;
        end else if (s2_valid && bus.out_ready && (|s2_sat) && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sat_cnt = cnt;

endmodule
`default_nettype wire

// File: tb/tb_grad_round_clip_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grad_round_clip_pipe
//  Description : Directed-vector bench for grad_round_clip_pipe. A scoreboard
//                computes each result from the arithmetic rules when a
//                vector is accepted and checks every valid output and the
//                saturation counter each cycle; directed literals pin the
//                model and the latency/backpressure/reset behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grad_round_clip_pipe;

    localparam int NUM_CH = 4;
    localparam int IN_W   = 16;
    localparam int FRAC   = 8;
    localparam int OUT_W  = 8;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] sat_cnt;

    grad_round_clip_pipe_if #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    grad_round_clip_pipe #(
        .NUM_CH(NUM_CH), .IN_W(IN_W), .FRAC(FRAC), .OUT_W(OUT_W), .CNT_W(CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cnt_clr (cnt_clr),
        .sat_cnt (sat_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int delivered = 0;
    int model_cnt = 0;
    bit chk_en = 1'b0;

    logic [31:0] exp_d[$];
    logic [3:0]  exp_s[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: round each word with integer arithmetic, then clamp.
    function automatic void model(input logic [63:0] d, input logic [1:0] m,
                                  input logic ce, input logic [6:0] lim,
                                  output logic [31:0] dout, output logic [3:0] sat);
        dout = '0;
        sat  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            int x, r, hi, lo, c;
            logic signed [15:0] w;
            w = d[k*16 +: 16];
            x = w;
            case (m)
                2'd1:    r = x >>> 8;
                2'd2:    r = (x >= 0) ? ((x + 128) >>> 8) : -((-x + 128) >>> 8);
                default: r = (x + 128) >>> 8;
            endcase
            hi = ce ? int'(lim) : 127;
            lo = ce ? -int'(lim) : -128;
            c  = (r > hi) ? hi : ((r < lo) ? lo : r);
            sat[k] = (c != r);
            dout[k*8 +: 8] = 8'(c);
        end
    endfunction

    // Scoreboard and counter model, evaluated mid-cycle.
    always @(negedge clk) begin
        logic [31:0] md;
        logic [3:0]  ms;
        bit          hs;
        bit          sat_any;
        if (chk_en) begin
            if (bus.out_valid === 1'b1) begin
                if (exp_d.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL out_unexpected: got out_valid=1 required no pending vector at %0t", $time);
                end else begin
                    check("sb_out_data", 64'(bus.out_data), 64'(exp_d[0]));
                    check("sb_out_sat",  64'(bus.out_sat),  64'(exp_s[0]));
                end
            end
            check("sb_sat_cnt", 64'(sat_cnt), 64'(model_cnt));

            hs      = (bus.out_valid === 1'b1) && bus.out_ready && (exp_d.size() > 0);
            sat_any = 1'b0;
            if (rst) begin
                model_cnt = 0;
                exp_d.delete();
                exp_s.delete();
            end else begin
                if (hs) begin
                    sat_any = |exp_s[0];
                    void'(exp_d.pop_front());
                    void'(exp_s.pop_front());
                    delivered++;
                end
                if (cnt_clr) model_cnt = 0;
                else if (hs && sat_any && model_cnt < CNT_MAX) model_cnt++;
                if (bus.in_valid && (bus.in_ready === 1'b1)) begin
                    model(bus.in_data, bus.mode, bus.clip_en, bus.clip_lim, md, ms);
                    exp_d.push_back(md);
                    exp_s.push_back(ms);
                end
            end
        end
    end

    // Present a vector and hold it until accepted; returns just after the
    // accepting edge with in_valid still high.
    task automatic send(input logic [63:0] d, input logic [1:0] m,
                        input logic ce, input logic [6:0] l);
        bit got;
        got = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.mode     = m;
        bus.clip_en  = ce;
        bus.clip_lim = l;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = (bus.in_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 for 20 cycles required 1");
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_d.size() > 0 && c < 40) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain_empty", 64'(exp_d.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] V1 = 64'h8000_7FFF_FE80_0180;
    localparam logic [63:0] VC = 64'h0000_0A00_F400_0C00;
    localparam logic [63:0] VS = 64'h0100_0100_0100_0100;

    logic [63:0] bp_vec [4];
    logic [31:0] md;
    logic [3:0]  ms;
    int          idx;
    int          d0;

    initial begin
        bp_vec[0] = 64'h0100_0200_0300_0400;
        bp_vec[1] = 64'hFF00_FE00_FD00_FC00;
        bp_vec[2] = 64'h0080_0180_0280_0380;
        bp_vec[3] = 64'h0040_FFC0_00C0_FF40;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.mode      = 2'd0;
        bus.clip_en   = 1'b0;
        bus.clip_lim  = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_out_sat",   64'(bus.out_sat),   64'd0);
        check("rst_sat_cnt",   64'(sat_cnt),       64'd0);
        @(posedge clk);
        #1;

        // Pin the reference model with hand-computed results
        model(V1, 2'd0, 1'b0, 7'd0, md, ms);
        check("model_m0_data", 64'(md), 64'h807FFF02);
        check("model_m0_sat",  64'(ms), 64'b0100);
        model(V1, 2'd1, 1'b0, 7'd0, md, ms);
        check("model_m1_data", 64'(md), 64'h807FFE01);
        check("model_m1_sat",  64'(ms), 64'b0000);
        model(V1, 2'd2, 1'b0, 7'd0, md, ms);
        check("model_m2_data", 64'(md), 64'h807FFE02);
        check("model_m2_sat",  64'(ms), 64'b0100);
        model(VC, 2'd0, 1'b1, 7'd10, md, ms);
        check("model_clip_data", 64'(md), 64'h000AF60A);
        check("model_clip_sat",  64'(ms), 64'b0011);

        // Latency: output appears two cycles after the input cycle
        send(V1, 2'd0, 1'b0, 7'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("lat_not_yet", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_valid", 64'(bus.out_valid), 64'd1);
        check("lat_data",  64'(bus.out_data),  64'h807FFF02);
        check("lat_sat",   64'(bus.out_sat),   64'b0100);
        @(posedge clk);
        #1;

        // Other rounding modes back-to-back, then clipping
        send(V1, 2'd1, 1'b0, 7'd0);
        send(V1, 2'd2, 1'b0, 7'd0);
        send(VC, 2'd0, 1'b1, 7'd10);
        bus.in_valid = 1'b0;
        drain();
        @(negedge clk);
        check("cnt_after_clip", 64'(sat_cnt), 64'd3);
        @(posedge clk);
        #1;

        // Backpressure: only two vectors fit while the output is stalled
        d0 = delivered;
        bus.out_ready = 1'b0;
        bus.mode      = 2'd0;
        bus.clip_en   = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = bp_vec[idx];
            @(negedge clk);
            if (bus.in_ready === 1'b1) idx++;
            @(posedge clk);
            #1;
        end
        check("bp_accepted", 64'(idx), 64'd2);
        @(negedge clk);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = bp_vec[idx];
            @(negedge clk);
            if (bus.in_ready === 1'b1) idx++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        drain();
        check("bp_delivered", 64'(delivered - d0), 64'd4);

        // Counter saturates
        for (int i = 0; i < 20; i++) send(VS, 2'd0, 1'b1, 7'd0);
        bus.in_valid = 1'b0;
        drain();
        @(negedge clk);
        check("cnt_saturated", 64'(sat_cnt), 64'(CNT_MAX));
        @(posedge clk);
        #1;

        // Clear wins over a same-cycle saturating delivery
        send(VS, 2'd0, 1'b1, 7'd0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("clr_out_valid", 64'(bus.out_valid), 64'd1);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        check("clr_priority", 64'(sat_cnt), 64'd0);
        @(posedge clk);
        #1;

        // Reset with two vectors in flight
        send(VS, 2'd0, 1'b1, 7'd0);
        send(VS, 2'd1, 1'b1, 7'd0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_cnt",   64'(sat_cnt),       64'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("rst_flushed", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(V1, 2'd0, 1'b0, 7'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_early", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_rst_valid", 64'(bus.out_valid), 64'd1);
        check("post_rst_data",  64'(bus.out_data),  64'h807FFF02);
        @(posedge clk);
        #1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish before 200000");
        $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
